uart_tx_ctrl: RTL and testbench

UART transmit-side controller. It accepts a parallel byte with a one-cycle valid strobe, latches it, and sequences the serial frame onto TX_OUT: start bit, data bits LSB-first, optional parity, stop.
It sits beside the RX path, shares the same configuration inputs (PAR_EN, PAR_TYP), and runs on the TX bit clock, one bit per clk cycle.
It owns the frame FSM, bit counter, shift register and parity generator.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_parity_calc.sv | 19 +
 rtl/uart_tx_ctrl.sv | 153 +++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART TX and RX paths.
//   uart_state_e : frame FSM state encoding (same numbering as the RX FSM)
//   PAR_EVEN/ODD : values of the PAR_TYP configuration input
//   START_BIT/STOP_BIT : serial line levels for the framing bits
//   CNT_W        : width of the bit/stop counter (covers DATA_WIDTH up to 9)
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam int CNT_W = 4;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// uart_tx_parity_calc: combinational parity generator, shared with the RX
// parity checker.
//   data    [WIDTH-1:0] in  : word to protect
//   par_typ             in  : PAR_EVEN (0) or PAR_ODD (1)
//   parity              out : bit that makes the total count of ones even/odd
module uart_tx_parity_calc
    import uart_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic             par_typ,
    output logic             parity
);

    // Odd parity is the even-parity bit inverted.
    assign parity = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit frame sequencer, one serial bit per clk cycle.
// Frame: start bit, DATA_WIDTH data bits LSB first, optional parity, stop.
//   clk        in  : TX bit clock
//   rst        in  : asynchronous active-low reset
//   P_DATA     in  : parallel data, latched on accept
//   Data_Valid in  : request strobe, honoured only while idle
//   PAR_EN     in  : 1 = insert parity bit (latched on accept)
//   PAR_TYP    in  : 0 = even, 1 = odd (latched on accept)
//   TX_OUT     out : serial line, idle high, registered
//   busy       out : high while a frame is on the line, registered
//   tx_done    out : one-cycle pulse in the cycle after the last stop bit
// Build option: define UART_TX_STOP2_EN for two stop bits.
//
// state  | meaning
// -------+---------------------------------------------
// IDLE   | line high, waiting for Data_Valid
// START  | start bit on the line
// DATA   | data bit bit_cnt on the line
// PARITY | latched parity bit on the line
// STOP   | stop bit(s); bit_cnt counts down remaining stop cycles
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic                  tx_done
);

`ifdef UART_TX_STOP2_EN
    localparam int STOP_BITS = 2;
`else
    localparam int STOP_BITS = 1;
`endif

    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] STOP_LOAD = CNT_W'(STOP_BITS - 1);

    uart_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  tx_out_d, busy_d, tx_done_d;
    logic                  par_calc;

    // Parity of P_DATA at the accept edge equals parity of the latched byte.
    uart_tx_parity_calc #(.WIDTH(DATA_WIDTH)) u_parity (
        .data    (P_DATA),
        .par_typ (PAR_TYP),
        .parity  (par_calc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            TX_OUT    <= STOP_BIT;
            busy      <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            TX_OUT    <= tx_out_d;
            busy      <= busy_d;
            tx_done   <= tx_done_d;
        end
    end

    // Outputs are computed for the state being entered, so the line level
    // changes on the same edge as the state.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        tx_out_d  = STOP_BIT;
        busy_d    = 1'b0;
        tx_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (Data_Valid) begin
                    state_d   = START;
                    shift_d   = P_DATA;
                    par_en_d  = PAR_EN;
                    par_bit_d = par_calc;
                    cnt_d     = '0;
                    tx_out_d  = START_BIT;
                    busy_d    = 1'b1;
                end
            end
            START: begin
                state_d  = DATA;
                tx_out_d = shift_q[0];
                shift_d  = shift_q >> 1;
                cnt_d    = '0;
                busy_d   = 1'b1;
            end
            DATA: begin
                busy_d = 1'b1;
                if (cnt_q == LAST_BIT) begin
                    if (par_en_q) begin
                        state_d  = PARITY;
                        tx_out_d = par_bit_q;
                    end else begin
                        state_d  = STOP;
                        tx_out_d = STOP_BIT;
                        cnt_d    = STOP_LOAD;
                    end
                end else begin
                    tx_out_d = shift_q[0];
                    shift_d  = shift_q >> 1;
                    cnt_d    = cnt_q + 1'b1;
                end
            end
            PARITY: begin
                state_d  = STOP;
                tx_out_d = STOP_BIT;
                cnt_d    = STOP_LOAD;
                busy_d   = 1'b1;
            end
            STOP: begin
                // Down-counter: terminal count zero ends the stop dwell.
                if (cnt_q == '0) begin
                    state_d   = IDLE;
                    tx_done_d = 1'b1;
                end else begin
                    cnt_d  = cnt_q - 1'b1;
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
module tb_uart_tx_ctrl;

    localparam int DW = 8;
`ifdef UART_TX_STOP2_EN
    localparam int STOPS = 2;
`else
    localparam int STOPS = 1;
`endif

    typedef struct {
        logic [15:0] bits;
        int          len;
        time         t_start;
    } frame_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] P_DATA = '0;
    logic          Data_Valid = 1'b0;
    logic          PAR_EN = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic          TX_OUT, busy, tx_done;

    int     errors = 0;
    int     checks = 0;
    frame_t exp_q[$];
    int     model_rem = 0;
    logic   mon_en = 1'b1;

    always #5 clk = ~clk;

    uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    // Reference: the serial bit sequence a frame must carry.
    function automatic frame_t make_frame(input logic [DW-1:0] d, input logic pen, input logic ptyp);
        frame_t f;
        int n;
        logic p;
        f.bits = '0;
        f.t_start = 0;
        n = 0;
        f.bits[n] = 1'b0; n++;
        for (int i = 0; i < DW; i++) begin
            f.bits[n] = d[i]; n++;
        end
        if (pen) begin
            p = (($countones(d) % 2) != 0) ^ ptyp;
            f.bits[n] = p; n++;
        end
        for (int s = 0; s < STOPS; s++) begin
            f.bits[n] = 1'b1; n++;
        end
        f.len = n;
        return f;
    endfunction

    // Drive one cycle of inputs; the model decides acceptance from its own
    // notion of when the transmitter is free.
    task automatic drive(input logic dv, input logic [DW-1:0] d, input logic pen, input logic pt);
        frame_t f;
        @(negedge clk);
        Data_Valid = dv;
        P_DATA     = d;
        PAR_EN     = pen;
        PAR_TYP    = pt;
        @(posedge clk);
        if (model_rem == 0) begin
            if (dv) begin
                f = make_frame(d, pen, pt);
                f.t_start = $time + 5;
                exp_q.push_back(f);
                model_rem = f.len;
            end
        end else begin
            model_rem--;
        end
    endtask

    // Monitor: assemble each busy run into a frame and compare with the queue.
    initial begin : monitor
        logic        collecting;
        logic [15:0] got;
        int          got_len;
        time         got_t;
        frame_t      e;
        collecting = 1'b0;
        got = '0;
        got_len = 0;
        got_t = 0;
        forever begin
            @(negedge clk);
            if (!rst || !mon_en) begin
                collecting = 1'b0;
            end else if (collecting) begin
                if (busy) begin
                    if (got_len < 16) got[got_len] = TX_OUT;
                    got_len++;
                    checks++;
                    if (tx_done !== 1'b0) begin
                        errors++;
                        $display("FAIL tx_done_in_frame: got %b required 0 at %0t", tx_done, $time);
                    end
                end else begin
                    collecting = 1'b0;
                    checks++;
                    if (tx_done !== 1'b1) begin
                        errors++;
                        $display("FAIL tx_done_pulse: got %b required 1 at %0t", tx_done, $time);
                    end
                    checks++;
                    if (TX_OUT !== 1'b1) begin
                        errors++;
                        $display("FAIL line_after_frame: got %b required 1 at %0t", TX_OUT, $time);
                    end
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_frame: got %h len %0d required no frame", got, got_len);
                    end else begin
                        e = exp_q.pop_front();
                        if (got_len != e.len || got !== e.bits) begin
                            errors++;
                            $display("FAIL frame_bits: got %h len %0d required %h len %0d", got, got_len, e.bits, e.len);
                        end
                        checks++;
                        if (got_t != e.t_start) begin
                            errors++;
                            $display("FAIL start_latency: got start at %0t required %0t", got_t, e.t_start);
                        end
                    end
                end
            end else begin
                if (busy) begin
                    collecting = 1'b1;
                    got = '0;
                    got[0] = TX_OUT;
                    got_len = 1;
                    got_t = $time;
                end else begin
                    checks++;
                    if (TX_OUT !== 1'b1 || tx_done !== 1'b0) begin
                        errors++;
                        $display("FAIL idle_line: got tx_out %b tx_done %b required 1 0 at %0t", TX_OUT, tx_done, $time);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        repeat (3) @(negedge clk);
        checks++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got %b%b%b required 100", TX_OUT, busy, tx_done);
        end
        rst = 1'b1;
        repeat (5) drive(1'b0, '0, 1'b0, 1'b0);

        // Directed frames
        drive(1'b1, 8'hA5, 1'b1, 1'b0);
        repeat (14) drive(1'b0, '0, 1'b0, 1'b0);
        drive(1'b1, 8'hA5, 1'b1, 1'b1);
        repeat (14) drive(1'b0, '0, 1'b0, 1'b0);
        drive(1'b1, 8'hA5, 1'b0, 1'b0);
        repeat (14) drive(1'b0, '0, 1'b0, 1'b0);
        drive(1'b1, 8'h81, 1'b0, 1'b0);
        repeat (14) drive(1'b0, '0, 1'b0, 1'b0);

        // Data_Valid held high; data switches mid-frame
        for (int i = 0; i < 30; i++)
            drive(1'b1, (i < 4) ? 8'h00 : 8'hFF, 1'b0, 1'b0);
        repeat (14) drive(1'b0, '0, 1'b0, 1'b0);

        // Reset during the 4th data bit of an 8'h3C frame
        @(negedge clk);
        mon_en = 1'b0;
        Data_Valid = 1'b1;
        P_DATA = 8'h3C;
        PAR_EN = 1'b0;
        @(posedge clk);
        @(negedge clk);
        Data_Valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (TX_OUT !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_bit3: got tx_out %b busy %b required 1 1", TX_OUT, busy);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: got %b%b%b required 100", TX_OUT, busy, tx_done);
        end
        @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;
        model_rem = 0;
        drive(1'b1, 8'h3C, 1'b1, 1'b1);
        repeat (14) drive(1'b0, '0, 1'b0, 1'b0);

        // Randomized traffic, including config changes mid-frame
        for (int i = 0; i < 400; i++)
            drive($urandom_range(0, 3) == 0, DW'($urandom), 1'($urandom), 1'($urandom));
        repeat (20) drive(1'b0, '0, 1'b0, 1'b0);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL frames_missing: got %0d outstanding required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
